lcd_write_arbiter: RTL and testbench

LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

---
 rtl/lcd_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// Two-requester round-robin arbiter serialising byte writes into one LCD controller, with an idle
// gap after each write. Define LCD_ARB_LOCK_EN to let a grantee hold the bus via iLOCK0/iLOCK1.
module lcd_write_arbiter #(
  parameter int unsigned GAP_CYCLES = 262142,
  parameter int unsigned CNT_W      = 18
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ0,
  input  logic       iREQ1,
  input  logic       iRS0,
  input  logic       iRS1,
  input  logic [7:0] iDATA0,
  input  logic [7:0] iDATA1,
  input  logic       iLOCK0,
  input  logic       iLOCK1,
  output logic       oACK0,
  output logic       oACK1,
  output logic       oLCD_START,
  output logic       oLCD_RS,
  output logic [7:0] oLCD_DATA,
  input  logic       iLCD_DONE,
  output logic       oBUSY,
  output logic       oOWNER
);

  typedef enum logic [1:0] {StIdle, StIssue, StGap, StAck} state_e;

  localparam logic [CNT_W-1:0] LastCnt = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_rs, w_rs_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_owner, w_owner_nxt;
  logic             w_gnt_vld, w_gnt_idx;
  logic             w_owner_lock;
  logic             w_locked;

`ifdef LCD_ARB_LOCK_EN
  logic r_lock, w_lock_nxt;

  assign w_owner_lock = r_owner ? iLOCK1 : iLOCK0;
  assign w_locked     = r_lock & w_owner_lock;
`else
  logic w_unused_lock;

  assign w_unused_lock = iLOCK0 ^ iLOCK1;
  assign w_owner_lock  = 1'b0;
  assign w_locked      = 1'b0;
`endif

  // While locked only the owner may win; otherwise ties go to the non-owner.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_owner;
    if (w_locked) begin
      w_gnt_vld = r_owner ? iREQ1 : iREQ0;
      w_gnt_idx = r_owner;
    end else if (iREQ0 && iREQ1) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = ~r_owner;
    end else if (iREQ0) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = 1'b0;
    end else if (iREQ1) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
    w_owner_nxt = r_owner;
`ifdef LCD_ARB_LOCK_EN
    w_lock_nxt  = r_lock;
`endif
    unique case (r_state)
      StIdle: begin
`ifdef LCD_ARB_LOCK_EN
        if (r_lock && !w_owner_lock) w_lock_nxt = 1'b0;
`endif
        if (w_gnt_vld) begin
          w_owner_nxt = w_gnt_idx;
          w_rs_nxt    = w_gnt_idx ? iRS1 : iRS0;
          w_data_nxt  = w_gnt_idx ? iDATA1 : iDATA0;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (iLCD_DONE) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (GAP_CYCLES == 0) ? StAck : StGap;
        end
      end
      StGap: begin
        if (r_cnt == LastCnt) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StAck;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StAck: begin
`ifdef LCD_ARB_LOCK_EN
        if (w_owner_lock) w_lock_nxt = 1'b1;
`endif
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_data  <= '0;
      r_owner <= 1'b1;
`ifdef LCD_ARB_LOCK_EN
      r_lock  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rs    <= w_rs_nxt;
      r_data  <= w_data_nxt;
      r_owner <= w_owner_nxt;
`ifdef LCD_ARB_LOCK_EN
      r_lock  <= w_lock_nxt;
`endif
    end
  end

  // Decoded from state so an asynchronous reset clears them immediately.
  assign oLCD_START = (r_state == StIssue);
  assign oBUSY      = (r_state != StIdle);
  assign oACK0      = (r_state == StAck) && !r_owner;
  assign oACK1      = (r_state == StAck) && r_owner;
  assign oLCD_RS    = r_rs;
  assign oLCD_DATA  = r_data;
  assign oOWNER     = r_owner;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomised scoreboard bench for lcd_write_arbiter (GAP_CYCLES = 4, controller answers DONE on
// the third START cycle); a transaction-level model predicts each ACK and the monitor checks it.
module tb_lcd_write_arbiter;
  localparam int unsigned GAP = 4;
  localparam int unsigned DoneAfter = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       done = 1'b0;
  logic       ack0, ack1, start, lcd_rs, busy, owner;
  logic [7:0] lcd_data;

  lcd_write_arbiter #(.GAP_CYCLES(GAP), .CNT_W(3)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iREQ0(req0), .iREQ1(req1), .iRS0(rs0), .iRS1(rs1),
    .iDATA0(data0), .iDATA1(data1), .iLOCK0(lock0), .iLOCK1(lock1),
    .oACK0(ack0), .oACK1(ack1), .oLCD_START(start), .oLCD_RS(lcd_rs), .oLCD_DATA(lcd_data),
    .iLCD_DONE(done), .oBUSY(busy), .oOWNER(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       idx;
    logic       rs;
    logic [7:0] data;
    int         at_edge;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0;
  int   ecnt = 0;
  bit   stray_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    ecnt++;
  end

  // LCD controller: DONE on the third START cycle; optional stray DONE pulses otherwise.
  initial begin
    int st = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) st = 0;
      else if (start) st++;
      else st = 0;
      done = (start && st == DoneAfter) ||
             (!start && stray_en && $urandom_range(0, 3) == 0);
    end
  end

  // Reference model: one write occupies the grant edge plus DONE, GAP and ACK cycles; the next
  // grant may happen on the edge after the IDLE cycle that follows the ACK.
  bit m_owner = 1'b1;
  bit m_lock = 1'b0;
  bit m_pend = 1'b0;
  int m_free = 0;
  int m_lock_at = 0;

  initial forever begin
    int  nxt;
    bit  w0, w1, pick;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      m_owner = 1'b1;
      m_lock  = 1'b0;
      m_pend  = 1'b0;
      m_free  = 0;
    end else begin
      nxt = ecnt + 1;
      if (m_pend && nxt == m_lock_at) begin
`ifdef LCD_ARB_LOCK_EN
        if (m_owner ? lock1 : lock0) m_lock = 1'b1;
`endif
        m_pend = 1'b0;
      end
      if (nxt >= m_free) begin
        w0 = req0;
        w1 = req1;
`ifdef LCD_ARB_LOCK_EN
        if (m_lock) begin
          if (m_owner ? lock1 : lock0) begin
            if (m_owner) w0 = 1'b0;
            else w1 = 1'b0;
          end else begin
            m_lock = 1'b0;
          end
        end
`endif
        if (w0 || w1) begin
          pick      = (w0 && w1) ? !m_owner : w1;
          e.idx     = pick;
          e.rs      = pick ? rs1 : rs0;
          e.data    = pick ? data1 : data0;
          e.at_edge = nxt + DoneAfter + GAP;
          sb.push_back(e);
          m_owner   = pick;
          m_free    = nxt + DoneAfter + GAP + 2;
          m_lock_at = nxt + DoneAfter + GAP + 1;
          m_pend    = 1'b1;
        end
      end
    end
  end

  // Monitor: every ACK pulse must match the oldest predicted write.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && (ack0 || ack1)) begin
      chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ack_expected: got ack0=%0b ack1=%0b, required no ACK (t=%0t)",
                 ack0, ack1, $time);
      end else begin
        e = sb.pop_front();
        chk("ack_idx", 32'(ack1), 32'(e.idx));
        chk("ack_time", 32'(ecnt), 32'(e.at_edge));
        chk("ack_owner", 32'(owner), 32'(e.idx));
        chk("lcd_rs", 32'(lcd_rs), 32'(e.rs));
        chk("lcd_data", 32'(lcd_data), 32'(e.data));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_owner", 32'(owner), 32'd1);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    rst_n = 1'b1;

    // Single command-free data write from requester 0.
    cyc(1);
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
    cyc(1);
    req0 = 1'b0;
    chk("start_after_grant", 32'(start), 32'd1);
    cyc(14);

    // Both held: alternating grants while payloads keep changing.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 45; i++) begin
      rs0 = 1'($urandom); rs1 = 1'($urandom);
      data0 = 8'($urandom); data1 = 8'($urandom);
      cyc(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc(12);

    // Requester 1 drops its request mid-write.
    req1 = 1'b1; rs1 = 1'b0; data1 = 8'h5a;
    cyc(3);
    req1 = 1'b0;
    cyc(12);

    // Reset while in GAP: abandoned write, then requester 0 wins the tie.
    req0 = 1'b1; rs0 = 1'b0; data0 = 8'h33;
    cyc(1);
    req0 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("gaprst_busy", 32'(busy), 32'd0);
    chk("gaprst_start", 32'(start), 32'd0);
    chk("gaprst_owner", 32'(owner), 32'd1);
    cyc(1);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h10; data1 = 8'h20;
    rst_n = 1'b1;
    cyc(1);
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_after_rst", 32'(owner), 32'd0);
    cyc(12);

`ifdef LCD_ARB_LOCK_EN
    // Burst lock by requester 0, then release.
    lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1;
    cyc(27);
    lock0 = 1'b0;
    cyc(18);
    req0 = 1'b0; req1 = 1'b0;
    cyc(12);
`endif

    // Random traffic with stray DONE pulses.
    stray_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      req0 = ($urandom_range(0, 2) != 0); req1 = ($urandom_range(0, 2) != 0);
      rs0 = 1'($urandom); rs1 = 1'($urandom);
      data0 = 8'($urandom); data1 = 8'($urandom);
      lock0 = ($urandom_range(0, 3) == 0); lock1 = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    cyc(15);
    stray_en = 1'b0;
    cyc(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("idle_at_end", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
